// File: rtl/lcd_write_engine.sv
// HD44780 write-only byte driver: power-up delay, fixed init sequence, then host bytes
// over a valid/ready handshake with setup / enable / hold / execution spacing.
module lcd_write_engine #(
  parameter int POWERUP_CYC = 750000,
  parameter int SETUP_CYC   = 3,
  parameter int EN_CYC      = 25,
  parameter int HOLD_CYC    = 2,
  parameter int EXEC_CYC    = 2000,
  parameter int CLEAR_CYC   = 82000
) (
  input  logic       clk_50M,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  localparam int MAX_AB  = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
  localparam int MAX_CD  = (EXEC_CYC > EN_CYC) ? EXEC_CYC : EN_CYC;
  localparam int MAX_EF  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_CYC = (MAX_ABC > MAX_EF) ? MAX_ABC : MAX_EF;
  localparam int CNT_W   = $clog2(MAX_CYC);

  // Each timed state loads (duration - 1) and leaves when the counter reads zero.
  // SETUP loads its full count because the load edge itself precedes the setup window.
  // WAIT loads (N - 2): its final cycle is spent in IDLE / INIT_LOAD, so a waiting
  // upstream byte is taken exactly N cycles after HOLD ends. N must be at least 2.
  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 2);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYC - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {PWR, INIT_LOAD, SETUP, EN, HOLD, WAIT, IDLE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       rom_idx, rom_idx_nxt;
  logic [7:0]       rom_byte;
  logic [7:0]       data_nxt;
  logic             rs_nxt, en_nxt, done_nxt, slow_cmd, lcd_on;

  always_comb begin
    case (rom_idx)
      2'd0:    rom_byte = 8'h38;
      2'd1:    rom_byte = 8'h0C;
      2'd2:    rom_byte = 8'h01;
      default: rom_byte = 8'h06;
    endcase
  end

  assign slow_cmd = !LCD_RS && (LCD_DATA == 8'h01 || LCD_DATA == 8'h02 || LCD_DATA == 8'h03);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rom_idx_nxt = rom_idx;
    data_nxt    = LCD_DATA;
    rs_nxt      = LCD_RS;
    en_nxt      = 1'b0;
    done_nxt    = init_done;
    case (state)
      PWR: begin
        if (cnt == '0) state_nxt = INIT_LOAD;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      INIT_LOAD: begin
        data_nxt  = rom_byte;
        rs_nxt    = 1'b0;
        cnt_nxt   = SETUP_LD;
        state_nxt = SETUP;
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = EN;
          en_nxt    = 1'b1;
          cnt_nxt   = EN_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      EN: begin
        en_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt = HOLD;
          en_nxt    = 1'b0;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = WAIT;
          cnt_nxt   = slow_cmd ? CLEAR_LD : EXEC_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (init_done) begin
          state_nxt = IDLE;
        end else if (rom_idx == 2'd3) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          rom_idx_nxt = rom_idx + 2'd1;
          state_nxt   = INIT_LOAD;
        end
      end
      IDLE: begin
        if (wr_valid) begin
          data_nxt  = wr_data;
          rs_nxt    = wr_rs;
          cnt_nxt   = SETUP_LD;
          state_nxt = SETUP;
        end
      end
      default: state_nxt = PWR;
    endcase
  end

  // Every LCD pin is a flop so the enable strobe cannot glitch; reset clears them asynchronously.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PWR;
      cnt       <= PWR_LD;
      rom_idx   <= 2'd0;
      LCD_DATA  <= 8'h00;
      LCD_RS    <= 1'b0;
      LCD_EN    <= 1'b0;
      lcd_on    <= 1'b0;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rom_idx   <= rom_idx_nxt;
      LCD_DATA  <= data_nxt;
      LCD_RS    <= rs_nxt;
      LCD_EN    <= en_nxt;
      lcd_on    <= 1'b1;
      wr_ready  <= (state_nxt == IDLE);
      init_done <= done_nxt;
    end
  end

  assign busy     = ~wr_ready;
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = lcd_on;
  assign LCD_BLON = lcd_on;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Self-checking bench for lcd_write_engine: expected bytes and edge timings come from
// the datasheet-level rules (cycle arithmetic), compared against a pin-level monitor.
module tb_lcd_write_engine;

  localparam int P = 100, S = 3, E = 25, H = 2, X = 20, C = 200;
  localparam int LOG_N = 128;

  logic       clk_50M = 1'b0;
  logic       reset_n = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, init_done, busy, LCD_EN, LCD_RW, LCD_RS, LCD_ON, LCD_BLON;
  logic [7:0] LCD_DATA;

  int checks = 0, failures = 0;
  int cyc = 0;

  lcd_write_engine #(
    .POWERUP_CYC(P), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .EXEC_CYC(X), .CLEAR_CYC(C)
  ) dut (
    .clk_50M(clk_50M), .reset_n(reset_n), .wr_valid(wr_valid), .wr_rs(wr_rs),
    .wr_data(wr_data), .wr_ready(wr_ready), .init_done(init_done), .busy(busy),
    .LCD_DATA(LCD_DATA), .LCD_EN(LCD_EN), .LCD_RW(LCD_RW), .LCD_RS(LCD_RS),
    .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
  );

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  // Pin monitor: edge numbers refer to the posedge count at which a change became visible.
  logic       en_q = 1'b0;
  int         rise_at = 0;
  int         wn = 0, an = 0;
  logic [7:0] w_data [LOG_N];
  logic       w_rs   [LOG_N];
  logic       w_rw   [LOG_N];
  int         w_rise [LOG_N];
  int         w_fall [LOG_N];
  int         acc_edge [LOG_N];

  always @(negedge clk_50M) begin
    if (!reset_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= LCD_EN;
      if (LCD_EN && !en_q) rise_at <= cyc;
      if (!LCD_EN && en_q && wn < LOG_N) begin
        w_data[wn] <= LCD_DATA;
        w_rs[wn]   <= LCD_RS;
        w_rw[wn]   <= LCD_RW;
        w_rise[wn] <= rise_at;
        w_fall[wn] <= cyc;
        wn         <= wn + 1;
      end
      if (wr_valid && wr_ready && an < LOG_N) begin
        acc_edge[an] <= cyc + 1;
        an           <= an + 1;
      end
    end
  end

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? C : X;
  endfunction

  function automatic int cycle_len(input logic rs, input logic [7:0] d);
    return 1 + S + E + H + wait_len(rs, d);
  endfunction

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!wr_ready && t < 2000) begin tick(); t++; end
    checkOutput(tag, 32'(wr_ready), 32'd1);
  endtask

  // Full handshake for one host byte, then checks the pin-level write and its timing.
  task automatic applyStimulus(input logic rs, input logic [7:0] d, input string tag);
    int a0, w0, t, acc, rdy;
    wait_ready({tag, "_ready"});
    a0 = an;
    w0 = wn;
    wr_rs = rs; wr_data = d; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0; wr_rs = 1'($urandom); wr_data = 8'($urandom);
    checkOutput({tag, "_accepted"}, 32'(an - a0), 32'd1);
    acc = acc_edge[a0];
    t = 0;
    while (!wr_ready && t < 1000) begin tick(); t++; end
    rdy = cyc + 1;
    checkOutput({tag, "_ready_gap"}, 32'(rdy - acc), 32'(cycle_len(rs, d)));
    checkOutput({tag, "_writes"}, 32'(wn - w0), 32'd1);
    checkOutput({tag, "_data"}, 32'(w_data[w0]), 32'(d));
    checkOutput({tag, "_rs"}, 32'(w_rs[w0]), 32'(rs));
    checkOutput({tag, "_rw"}, 32'(w_rw[w0]), 32'd0);
    checkOutput({tag, "_en_delay"}, 32'(w_rise[w0] - acc), 32'(S + 1));
    checkOutput({tag, "_en_width"}, 32'(w_fall[w0] - w_rise[w0]), 32'(E));
  endtask

  task automatic verify_init(input int rel, input int base, input string tag, output int done_edge);
    logic [7:0] rom [4];
    int load, t, a0;
    bit early;
    rom = '{8'h38, 8'h0C, 8'h01, 8'h06};
    a0 = an;
    early = 1'b0;
    t = 0;
    tick();
    checkOutput({tag, "_lcd_on"}, 32'(LCD_ON), 32'd1);
    checkOutput({tag, "_lcd_blon"}, 32'(LCD_BLON), 32'd1);
    while (!init_done && t < 3000) begin
      if (wr_ready) early = 1'b1;
      tick();
      t++;
    end
    done_edge = cyc + 1;
    checkOutput({tag, "_done"}, 32'(init_done), 32'd1);
    checkOutput({tag, "_ready_with_done"}, 32'(wr_ready), 32'd1);
    checkOutput({tag, "_busy_with_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ready_early"}, 32'(early), 32'd0);
    checkOutput({tag, "_write_count"}, 32'(wn - base), 32'd4);
    checkOutput({tag, "_no_accepts"}, 32'(an - a0), 32'd0);
    load = rel + P + 1;
    for (int k = 0; k < 4; k++) begin
      checkOutput({tag, "_data"}, 32'(w_data[base + k]), 32'(rom[k]));
      checkOutput({tag, "_rs"}, 32'(w_rs[base + k]), 32'd0);
      checkOutput({tag, "_rw"}, 32'(w_rw[base + k]), 32'd0);
      checkOutput({tag, "_rise"}, 32'(w_rise[base + k]), 32'(load + S + 1));
      checkOutput({tag, "_width"}, 32'(w_fall[base + k] - w_rise[base + k]), 32'(E));
      load += cycle_len(1'b0, rom[k]);
    end
    checkOutput({tag, "_first_rise"}, 32'(w_rise[base] - rel), 32'(P + S + 2));
    checkOutput({tag, "_done_edge"}, 32'(done_edge), 32'(load));
  endtask

  logic [7:0] stream_b [3] = '{8'h48, 8'h49, 8'h21};
  int rel, base, done_e, a0, w0, sent, t;
  logic r;
  logic [7:0] d;

  initial begin
    $display("[TB] reset and power-up init");
    #1 reset_n = 1'b0;
    #2;
    checkOutput("rst_en", 32'(LCD_EN), 32'd0);
    checkOutput("rst_data", 32'(LCD_DATA), 32'd0);
    checkOutput("rst_rs", 32'(LCD_RS), 32'd0);
    checkOutput("rst_rw", 32'(LCD_RW), 32'd0);
    checkOutput("rst_on", 32'(LCD_ON), 32'd0);
    checkOutput("rst_blon", 32'(LCD_BLON), 32'd0);
    checkOutput("rst_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_done", 32'(init_done), 32'd0);
    repeat (3) tick();
    checkOutput("rst_on_held", 32'(LCD_ON), 32'd0);
    reset_n = 1'b1;
    rel = cyc;
    base = wn;
    verify_init(rel, base, "init1", done_e);

    $display("[TB] single and random host bytes");
    applyStimulus(1'b1, 8'h41, "data41");
    for (int i = 0; i < 6; i++) begin
      r = 1'($urandom_range(0, 1));
      d = (i % 3 == 2) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      applyStimulus(r, d, "rand");
    end

    $display("[TB] streaming with valid held");
    wait_ready("stream_ready");
    a0 = an;
    w0 = wn;
    sent = 0;
    t = 0;
    wr_valid = 1'b1;
    while (sent < 3 && t < 1000) begin
      if (wr_ready) begin
        wr_rs = 1'b1;
        wr_data = stream_b[sent];
      end else begin
        wr_rs = 1'($urandom);
        wr_data = 8'($urandom);
      end
      tick();
      t++;
      if (an > a0 + sent) sent++;
    end
    wr_valid = 1'b0;
    t = 0;
    while (!wr_ready && t < 1000) begin tick(); t++; end
    checkOutput("stream_accepts", 32'(an - a0), 32'd3);
    checkOutput("stream_writes", 32'(wn - w0), 32'd3);
    for (int k = 0; k < 3; k++) begin
      checkOutput("stream_data", 32'(w_data[w0 + k]), 32'(stream_b[k]));
      checkOutput("stream_rs", 32'(w_rs[w0 + k]), 32'd1);
    end
    checkOutput("stream_gap1", 32'(acc_edge[a0 + 1] - acc_edge[a0]), 32'(cycle_len(1'b1, stream_b[0])));
    checkOutput("stream_gap2", 32'(acc_edge[a0 + 2] - acc_edge[a0 + 1]), 32'(cycle_len(1'b1, stream_b[1])));
    checkOutput("stream_last_ready", 32'(cyc + 1 - acc_edge[a0 + 2]), 32'(cycle_len(1'b1, stream_b[2])));

    $display("[TB] clear/home versus data timing");
    applyStimulus(1'b0, 8'h01, "clear");
    applyStimulus(1'b1, 8'h01, "data01");
    applyStimulus(1'b0, 8'h02, "home");
    applyStimulus(1'b0, 8'h03, "instr03");
    applyStimulus(1'b0, 8'h04, "instr04");
    applyStimulus(1'b0, 8'h00, "instr00");

    $display("[TB] reset mid-pulse with early request");
    wait_ready("pre_rst_ready");
    wr_rs = 1'b1; wr_data = 8'h5A; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    t = 0;
    while (!LCD_EN && t < 100) begin tick(); t++; end
    checkOutput("pre_rst_en", 32'(LCD_EN), 32'd1);
    #5 reset_n = 1'b0;
    #1;
    checkOutput("midrst_en", 32'(LCD_EN), 32'd0);
    checkOutput("midrst_on", 32'(LCD_ON), 32'd0);
    checkOutput("midrst_ready", 32'(wr_ready), 32'd0);
    checkOutput("midrst_done", 32'(init_done), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd1);
    checkOutput("midrst_data", 32'(LCD_DATA), 32'd0);
    wr_rs = 1'b1; wr_data = 8'h55; wr_valid = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    rel = cyc;
    base = wn;
    a0 = an;
    verify_init(rel, base, "init2", done_e);
    tick();
    wr_valid = 1'b0;
    checkOutput("early_accepts", 32'(an - a0), 32'd1);
    checkOutput("early_accept_edge", 32'(acc_edge[a0]), 32'(done_e));
    t = 0;
    while (!wr_ready && t < 1000) begin tick(); t++; end
    checkOutput("early_writes", 32'(wn - base), 32'd5);
    checkOutput("early_data", 32'(w_data[base + 4]), 32'h55);
    checkOutput("early_rs", 32'(w_rs[base + 4]), 32'd1);
    checkOutput("early_rise", 32'(w_rise[base + 4] - done_e), 32'(S + 1));
    checkOutput("early_ready_gap", 32'(cyc + 1 - done_e), 32'(cycle_len(1'b1, 8'h55)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
